// File: rtl/tmds_decoder.sv
// TMDS receive channel: decodes 10-bit symbols to pixel bytes or control bits and
// recovers word alignment by counting control tokens and requesting bitslips.
module tmds_decoder #(
  parameter int unsigned LOCK_TOKENS   = 8,
  parameter int unsigned SEARCH_CYCLES = 1024,
  parameter int unsigned SLIP_WAIT     = 16,
  parameter int unsigned MAX_ACTIVE    = 4096
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  logic [9:0] i_symbol,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic       o_bitslip,
  output logic [3:0] o_slip_cnt
);

  localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned SRCH_W = $clog2(SEARCH_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int unsigned ACT_W  = $clog2(MAX_ACTIVE + 1);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TOK_W-1:0]  tok_cnt, tok_cnt_nxt;
  logic [SRCH_W-1:0] srch_cnt, srch_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ACT_W-1:0]  act_cnt, act_cnt_nxt;
  logic [3:0]        slip_cnt_nxt;
  logic              slip_req;

  logic              sym_tok;
  logic [1:0]        sym_ctrl;
  logic [9:0]        s1_sym;
  logic              s1_tok;
  logic [1:0]        s1_ctrl;
  logic [7:0]        s1_b;
  logic [7:0]        s1_data;

  // Control token classification of the incoming symbol
  always_comb begin
    sym_tok  = 1'b1;
    sym_ctrl = 2'b00;
    case (i_symbol)
      10'b1101010100: sym_ctrl = 2'b00;
      10'b0010101011: sym_ctrl = 2'b01;
      10'b0101010100: sym_ctrl = 2'b10;
      10'b1010101011: sym_ctrl = 2'b11;
      default:        sym_tok  = 1'b0;
    endcase
  end

  // Stage 1: register symbol and its classification
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_sym  <= '0;
      s1_tok  <= 1'b0;
      s1_ctrl <= 2'b00;
    end else begin
      s1_sym  <= i_symbol;
      s1_tok  <= sym_tok;
      s1_ctrl <= sym_ctrl;
    end
  end

  // Data-period decode: undo optional inversion, then undo XOR/XNOR chaining
  always_comb begin
    s1_b       = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    s1_data    = '0;
    s1_data[0] = s1_b[0];
    for (int i = 1; i < 8; i++) begin
      s1_data[i] = s1_sym[8] ? (s1_b[i] ^ s1_b[i-1]) : ~(s1_b[i] ^ s1_b[i-1]);
    end
  end

  // Lock FSM state and counters
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_SEARCH;
      tok_cnt  <= '0;
      srch_cnt <= '0;
      wait_cnt <= '0;
      act_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tok_cnt  <= tok_cnt_nxt;
      srch_cnt <= srch_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      act_cnt  <= act_cnt_nxt;
    end
  end

  // Lock FSM next-state; lock detection wins over the search timeout
  always_comb begin
    state_nxt    = state;
    tok_cnt_nxt  = tok_cnt;
    srch_cnt_nxt = srch_cnt;
    wait_cnt_nxt = wait_cnt;
    act_cnt_nxt  = act_cnt;
    slip_cnt_nxt = o_slip_cnt;
    slip_req     = 1'b0;
    case (state)
      ST_SEARCH: begin
        tok_cnt_nxt  = s1_tok ? tok_cnt + TOK_W'(1) : '0;
        srch_cnt_nxt = srch_cnt + SRCH_W'(1);
        if (s1_tok && (tok_cnt == TOK_W'(LOCK_TOKENS - 1))) begin
          state_nxt    = ST_LOCKED;
          tok_cnt_nxt  = '0;
          srch_cnt_nxt = '0;
          act_cnt_nxt  = '0;
        end else if (srch_cnt == SRCH_W'(SEARCH_CYCLES - 1)) begin
          state_nxt    = ST_SLIP_WAIT;
          slip_req     = 1'b1;
          slip_cnt_nxt = (o_slip_cnt == 4'd9) ? 4'd0 : o_slip_cnt + 4'd1;
          wait_cnt_nxt = '0;
          tok_cnt_nxt  = '0;
          srch_cnt_nxt = '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_nxt    = ST_SEARCH;
          wait_cnt_nxt = '0;
          tok_cnt_nxt  = '0;
          srch_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        act_cnt_nxt = s1_tok ? '0 : act_cnt + ACT_W'(1);
        if (!s1_tok && (act_cnt == ACT_W'(MAX_ACTIVE - 1))) begin
          state_nxt    = ST_SEARCH;
          act_cnt_nxt  = '0;
          tok_cnt_nxt  = '0;
          srch_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_SEARCH;
        tok_cnt_nxt  = '0;
        srch_cnt_nxt = '0;
        wait_cnt_nxt = '0;
        act_cnt_nxt  = '0;
      end
    endcase
  end

  // Stage 2: outputs qualified by the state this symbol leads to
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data     <= '0;
      o_ctrl     <= '0;
      o_de       <= 1'b0;
      o_locked   <= 1'b0;
      o_bitslip  <= 1'b0;
      o_slip_cnt <= '0;
    end else begin
      o_locked   <= (state_nxt == ST_LOCKED);
      o_bitslip  <= slip_req;
      o_slip_cnt <= slip_cnt_nxt;
      if (state_nxt != ST_LOCKED) begin
        o_data <= '0;
        o_ctrl <= '0;
        o_de   <= 1'b0;
      end else if (s1_tok) begin
        o_ctrl <= s1_ctrl;
        o_de   <= 1'b0;
      end else begin
        o_data <= s1_data;
        o_de   <= 1'b1;
      end
    end
  end

endmodule
